xlib_dma_rd_sched: RTL and testbench
====================================

// Module: xlib_dma_rd_sched
// PURPOSE
//  Sequences one DMA read job: accepts a descriptor (address, primitive count, bpp) and
//  programs the word-to-primitive stream converter (bpp, clear).
//  Issues credit-limited Avalon-MM burst reads into the receive FIFO that feeds the
//  converter, and marks the last returned word with EOF.
//  Counts primitives leaving the converter and pulses done when the job has fully drained.
// PARAMETERS
//  AW=32         Avalon byte address width
//  DW=32         data word width, power-of-2 bytes, same as the converter's DW
//  BW=8          byte width
//  AL=$clog2(DW/BW)  bpp field width, same as the converter's AL
//  LW=24         primitive-count width
//  BURST=8       maximum burst length in words, power of 2
//  FIFO_DEPTH=16 receive FIFO depth in words, >=BURST
// PORTS
//  clk          in  1        clock
//  rst_n        in  1        synchronous active-low reset
//  cmd_rdy      out 1        descriptor accepted when cmd_rdy && cmd_val
//  cmd_val      in  1        descriptor valid
//  cmd_addr     in  AW       start byte address; low log2(DW/BW) bits ignored (treated 0)
//  cmd_len      in  LW       number of primitives
//  cmd_bpp      in  AL       bytes per primitive minus 1
//  cfg_bpp      out AL       to converter bpp; held for the whole job
//  cfg_clr_n    out 1        to converter clr_n; low for exactly 1 cycle per job
//  av_address   out AW       Avalon read address, word aligned
//  av_read      out 1        Avalon read request
//  av_burstcount out $clog2(BURST)+1  words in the burst
//  av_waitrequest in 1       Avalon stall
//  av_readdatavalid in 1     one returned word
//  rd_eof       out 1        combinational: av_readdatavalid && last word of job; drives FIFO eof bit
//  fifo_pop     in  1        converter consumed one FIFO word (m_val && m_rdy)
//  prim_fire    in  1        converter output one primitive (s_val && s_rdy)
//  busy         out 1        state != IDLE
//  done         out 1        1-cycle pulse at job completion
// BEHAVIOUR
//  Reset values: state=IDLE, cmd_rdy=1, cfg_bpp=0, cfg_clr_n=1, av_read=0, av_address=0,
//   av_burstcount=0, done=0, busy=0, all counters 0.
//  Reset mid-job aborts immediately; in-flight Avalon responses are dropped.
//   The slave and FIFO must be reset together with this block.
//  FSM:
//   IDLE: cmd_rdy=1; on accept, latch addr/bpp -> CLEAR.
//    words = ceil(cmd_len*(cmd_bpp+1)/(DW/BW)), width LW+AL; prim_left=cmd_len.
//   CLEAR: 1 cycle, cfg_clr_n=0, cfg_bpp already valid.
//    -> DONE if cmd_len==0, else -> ISSUE.
//   ISSUE: burst = min(BURST, req_left).
//    Assert av_read only when credit + burst <= FIFO_DEPTH.
//    On av_read && !av_waitrequest: address += burst*DW/BW, req_left -= burst, credit += burst.
//    address/burstcount/read stay stable while av_waitrequest=1.
//    -> DRAIN when req_left reaches 0 on an accepted command.
//   DRAIN: -> DONE when rx_left==0 && prim_left==0.
//   DONE: done=1 for 1 cycle -> IDLE.
//  Counters:
//   credit (width $clog2(FIFO_DEPTH)+1): +burst on accepted command, -1 on fifo_pop.
//    Both in one cycle apply net; never exceeds FIFO_DEPTH.
//   rx_left: loaded with words; -1 on av_readdatavalid.
//   prim_left: -1 on prim_fire.
//   av_readdatavalid at rx_left==0 and prim_fire at prim_left==0 are ignored (no wrap).
//  rd_eof is asserted with the returned word where rx_left==1.
//  Bursts do not split on address boundaries; the slave must accept any start.
//  A new descriptor is accepted only in IDLE; back-to-back jobs are separated by CLEAR+DONE.
// TESTING
//  1. DW=32,BURST=8,FIFO=16, len=16,bpp=3,addr=0x100, pop every word
//     -> bursts (0x100,8),(0x120,8); rd_eof on 16th valid; done after 16th prim_fire.
//  2. len=5,bpp=2 (15B)
//     -> words=4, single burst of 4; rd_eof on 4th valid; done after 5 prim_fire.
//  3. FIFO=8, no fifo_pop, len=32,bpp=3
//     -> one burst of 8, then av_read=0; 8 pops -> next burst issues.
//  4. av_waitrequest=1 for 5 cycles on first burst
//     -> av_address/av_burstcount constant, exactly one command accepted.
//  5. len=0
//     -> cfg_clr_n low 1 cycle, av_read never high, done 2 cycles after accept.
//  6. rst_n=0 during ISSUE with av_read=1
//     -> next cycle av_read=0, busy=0, cmd_rdy=1, cfg_clr_n=1.

Source files
------------

// File: rtl/xlib_dma_rd_sched_if.sv
// Descriptor and Avalon-MM read bundle of the DMA read scheduler.
// master = scheduler side, slave = descriptor source / Avalon slave side.
interface xlib_dma_rd_sched_if #(
    parameter int AW  = 32,
    parameter int LW  = 24,
    parameter int AL  = 2,
    parameter int BCW = 4
);
    logic          cmd_rdy;
    logic          cmd_val;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic [AL-1:0] cmd_bpp;

    logic [AW-1:0]  av_address;
    logic           av_read;
    logic [BCW-1:0] av_burstcount;
    logic           av_waitrequest;
    logic           av_readdatavalid;

    modport master (
        output cmd_rdy,
        input  cmd_val,
        input  cmd_addr,
        input  cmd_len,
        input  cmd_bpp,
        output av_address,
        output av_read,
        output av_burstcount,
        input  av_waitrequest,
        input  av_readdatavalid
    );

    modport slave (
        input  cmd_rdy,
        output cmd_val,
        output cmd_addr,
        output cmd_len,
        output cmd_bpp,
        input  av_address,
        input  av_read,
        input  av_burstcount,
        output av_waitrequest,
        output av_readdatavalid
    );
endinterface

// File: rtl/xlib_dma_rd_sched.sv
// DMA read job scheduler: descriptor in, credit-limited Avalon bursts out,
// EOF marking on the last word and done once all primitives have drained.
module xlib_dma_rd_sched #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int BW         = 8,
    parameter int AL         = $clog2(DW / BW),
    parameter int LW         = 24,
    parameter int BURST      = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    xlib_dma_rd_sched_if.master  bus,
    output logic [AL-1:0]        cfg_bpp,
    output logic                 cfg_clr_n,
    output logic                 rd_eof,
    input  logic                 fifo_pop,
    input  logic                 prim_fire,
    output logic                 busy,
    output logic                 done
);
    localparam int BPW = DW / BW;
    localparam int OFS = $clog2(BPW);
    localparam int BCW = $clog2(BURST) + 1;
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int WW  = LW + AL;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state;
    logic [AW-1:0]   addr;
    logic [WW-1:0]   req_left;
    logic [WW-1:0]   rx_left;
    logic [LW-1:0]   prim_left;
    logic [CW-1:0]   credit;

    logic [WW:0]     bytes_rnd;
    logic [WW-1:0]   words;
    logic [BCW-1:0]  burst;
    logic [CW:0]     cred_need;
    logic [CW-1:0]   cr_add;
    logic [CW-1:0]   cr_sub;
    logic            accept;
    logic            issued;

    // byte count rounded up to whole words before the shift
    assign bytes_rnd = (WW+1)'(bus.cmd_len) * ((WW+1)'(bus.cmd_bpp) + (WW+1)'(1))
                     + (WW+1)'(BPW - 1);
    assign words     = WW'(bytes_rnd >> OFS);

    assign burst     = (req_left >= WW'(BURST)) ? BCW'(BURST) : req_left[BCW-1:0];
    assign cred_need = (CW+1)'(credit) + (CW+1)'(burst);

    assign accept    = bus.cmd_rdy && bus.cmd_val;
    assign issued    = bus.av_read && !bus.av_waitrequest;
    assign cr_add    = issued ? CW'(bus.av_burstcount) : '0;
    assign cr_sub    = (fifo_pop && credit != '0) ? CW'(1) : '0;

    assign rd_eof    = bus.av_readdatavalid && (rx_left == WW'(1));
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= S_IDLE;
            bus.cmd_rdy       <= 1'b1;
            cfg_bpp           <= '0;
            cfg_clr_n         <= 1'b1;
            bus.av_read       <= 1'b0;
            bus.av_address    <= '0;
            bus.av_burstcount <= '0;
            done              <= 1'b0;
            addr              <= '0;
            req_left          <= '0;
            rx_left           <= '0;
            prim_left         <= '0;
            credit            <= '0;
        end else begin
            credit    <= credit + cr_add - cr_sub;
            done      <= 1'b0;
            cfg_clr_n <= 1'b1;
            if (bus.av_readdatavalid && rx_left != '0)
                rx_left <= rx_left - WW'(1);
            if (prim_fire && prim_left != '0)
                prim_left <= prim_left - LW'(1);

            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        addr        <= bus.cmd_addr & ~AW'(BPW - 1);
                        cfg_bpp     <= bus.cmd_bpp;
                        req_left    <= words;
                        rx_left     <= words;
                        prim_left   <= bus.cmd_len;
                        bus.cmd_rdy <= 1'b0;
                        cfg_clr_n   <= 1'b0;
                        state       <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (prim_left == '0) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!bus.av_read) begin
                        if (cred_need <= (CW+1)'(FIFO_DEPTH)) begin
                            bus.av_read       <= 1'b1;
                            bus.av_address    <= addr;
                            bus.av_burstcount <= burst;
                        end
                    end else if (!bus.av_waitrequest) begin
                        bus.av_read <= 1'b0;
                        addr        <= addr + (AW'(bus.av_burstcount) << OFS);
                        req_left    <= req_left - WW'(bus.av_burstcount);
                        if (req_left == WW'(bus.av_burstcount))
                            state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (rx_left == '0 && prim_left == '0) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    bus.cmd_rdy <= 1'b1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_xlib_dma_rd_sched.sv
// Bench for xlib_dma_rd_sched: Avalon slave, FIFO and converter modelled at
// transaction level; expected bursts and counts derived from the job arithmetic.
module tb_xlib_dma_rd_sched;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int BW  = 8;
    localparam int AL  = 2;
    localparam int LW  = 24;
    localparam int BRS = 8;
    localparam int FD  = 16;
    localparam int BCW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    xlib_dma_rd_sched_if #(.AW(AW), .LW(LW), .AL(AL), .BCW(BCW)) bus ();

    logic [AL-1:0] cfg_bpp;
    logic          cfg_clr_n;
    logic          rd_eof;
    logic          fifo_pop = 1'b0;
    logic          prim_fire = 1'b0;
    logic          busy;
    logic          done;

    xlib_dma_rd_sched #(
        .AW(AW), .DW(DW), .BW(BW), .AL(AL), .LW(LW),
        .BURST(BRS), .FIFO_DEPTH(FD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .cfg_bpp   (cfg_bpp),
        .cfg_clr_n (cfg_clr_n),
        .rd_eof    (rd_eof),
        .fifo_pop  (fifo_pop),
        .prim_fire (prim_fire),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        logic [31:0] a;
        int          c;
    } burst_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int job_len = 0, job_bpp = 0, job_words = 0;
    int valid_cnt = 0, prim_cnt = 0, acc_cnt = 0;
    int pending = 0, fifo_cnt = 0, outstanding = 0, pool = 0;
    int last_evt = 0;
    int force_wait = 0;
    bit pop_en = 1'b1;
    bit hold_chk = 1'b0;
    logic [AW-1:0]  hold_a;
    logic [BCW-1:0] hold_c;
    burst_t exp_q[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Avalon slave, receive FIFO and converter, acting every negedge
    always @(negedge clk) begin
        burst_t b;
        #2;
        if (!rst_n) begin
            bus.av_waitrequest   = 1'b0;
            bus.av_readdatavalid = 1'b0;
            fifo_pop    = 1'b0;
            prim_fire   = 1'b0;
            pending     = 0;
            fifo_cnt    = 0;
            outstanding = 0;
            pool        = 0;
            hold_chk    = 1'b0;
        end else begin
            if (hold_chk) begin
                chk("hold_read", bus.av_read, 1);
                chk("hold_addr", bus.av_address, hold_a);
                chk("hold_bcnt", bus.av_burstcount, hold_c);
            end
            if (busy) chk("cfg_bpp_hold", cfg_bpp, job_bpp);
            if (bus.av_read) chk("read_has_burst", exp_q.size() != 0, 1);

            bus.av_waitrequest = (force_wait > 0) ? 1'b1
                               : ($urandom_range(0, 2) == 0);
            if (bus.av_read && force_wait > 0) force_wait--;
            hold_chk = bus.av_read && bus.av_waitrequest;
            hold_a   = bus.av_address;
            hold_c   = bus.av_burstcount;

            if (bus.av_read && !bus.av_waitrequest && exp_q.size() != 0) begin
                b = exp_q.pop_front();
                acc_cnt++;
                chk("av_address", bus.av_address, b.a);
                chk("av_burstcount", bus.av_burstcount, b.c);
                chk("credit_limit",
                    (outstanding + int'(bus.av_burstcount)) <= FD, 1);
                pending     += b.c;
                outstanding += b.c;
            end

            bus.av_readdatavalid = (pending > 0) && ($urandom_range(0, 1) == 1);
            fifo_pop  = pop_en && (fifo_cnt > 0) && ($urandom_range(0, 2) != 0);
            prim_fire = (prim_cnt < job_len) && (pool >= job_bpp + 1)
                      && ($urandom_range(0, 3) != 0);
            if (prim_fire) begin
                pool -= job_bpp + 1;
                prim_cnt++;
                last_evt = cyc;
            end
            if (fifo_pop) begin
                fifo_cnt--;
                outstanding--;
                pool += DW / BW;
            end
            if (bus.av_readdatavalid) begin
                pending--;
                valid_cnt++;
                fifo_cnt++;
                last_evt = cyc;
            end
            #1;
            chk("rd_eof", rd_eof,
                bus.av_readdatavalid && (valid_cnt == job_words));
        end
    end

    task automatic start_job(input logic [31:0] a, input int len, input int bpp);
        burst_t b;
        job_len   = len;
        job_bpp   = bpp;
        job_words = (len * (bpp + 1) + 3) / 4;
        valid_cnt = 0;
        prim_cnt  = 0;
        acc_cnt   = 0;
        pool      = 0;
        exp_q.delete();
        for (int i = 0; i * BRS < job_words; i++) begin
            b.a = (a & 32'hFFFF_FFFC) + 32'(32 * i);
            b.c = (job_words - BRS * i > BRS) ? BRS : job_words - BRS * i;
            exp_q.push_back(b);
        end
        @(negedge clk);
        chk("cmd_rdy_idle", bus.cmd_rdy, 1);
        bus.cmd_val  = 1'b1;
        bus.cmd_addr = a;
        bus.cmd_len  = LW'(len);
        bus.cmd_bpp  = AL'(bpp);
        last_evt     = cyc;
        @(negedge clk);
        bus.cmd_val = 1'b0;
        chk("clr_n_low", cfg_clr_n, 0);
        chk("cfg_bpp", cfg_bpp, bpp);
        chk("busy_job", busy, 1);
        chk("cmd_rdy_busy", bus.cmd_rdy, 0);
        @(negedge clk);
        chk("clr_n_high", cfg_clr_n, 1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_done_lat"}, cyc - last_evt, 2);
        chk({tag, "_prims"}, prim_cnt, job_len);
        chk({tag, "_words"}, valid_cnt, job_words);
        chk({tag, "_bursts_left"}, exp_q.size(), 0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_rdy"}, bus.cmd_rdy, 1);
        n = 0;
        while (fifo_cnt != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        bus.cmd_val  = 1'b0;
        bus.cmd_addr = '0;
        bus.cmd_len  = '0;
        bus.cmd_bpp  = '0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_rdy", bus.cmd_rdy, 1);
        chk("rst_av_read", bus.av_read, 0);
        chk("rst_av_addr", bus.av_address, 0);
        chk("rst_av_bcnt", bus.av_burstcount, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_clr_n", cfg_clr_n, 1);
        chk("rst_bpp", cfg_bpp, 0);
        rst_n = 1'b1;

        start_job(32'h100, 16, 3);
        wait_done("t1");

        start_job(32'h200, 5, 2);
        wait_done("t2");

        pop_en = 1'b0;
        start_job(32'h800, 32, 3);
        repeat (60) @(negedge clk);
        chk("stall_bursts", acc_cnt, FD / BRS);
        chk("stall_read", bus.av_read, 0);
        pop_en = 1'b1;
        wait_done("t3");

        force_wait = 5;
        start_job(32'h1003, 16, 3);
        wait_done("t4");

        start_job(32'h300, 0, 1);
        wait_done("t5");

        for (int j = 0; j < 6; j++) begin
            start_job($urandom(), $urandom_range(1, 40), $urandom_range(0, 3));
            wait_done("rnd");
        end

        force_wait = 1000;
        start_job(32'h4000, 64, 3);
        n = 0;
        while (!bus.av_read && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t6_read_up", bus.av_read, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_av_read", bus.av_read, 0);
        chk("t6_busy", busy, 0);
        chk("t6_cmd_rdy", bus.cmd_rdy, 1);
        chk("t6_clr_n", cfg_clr_n, 1);
        force_wait = 0;
        rst_n = 1'b1;

        start_job(32'h500, 9, 1);
        wait_done("t7");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
